// File: rtl/dsram_dma_if.sv
// rtl/dsram_dma_if.sv - RAM-side port bundle between the DMA engine and a distributed RAM
//
// Groups the single-read / single-write RAM port:
//   mem_dout_addr  read address (async read)
//   mem_dout       read data returned by the RAM
//   mem_we         write enable (sync write)
//   mem_din_addr   write address
//   mem_din        write data
// master: the engine that drives addresses and writes; slave: the RAM.
interface dsram_dma_if #(
  parameter int WIDTH      = 13,
  parameter int DATA_WIDTH = 16
);
  logic [WIDTH-1:0]      mem_dout_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  mem_we;
  logic [WIDTH-1:0]      mem_din_addr;
  logic [DATA_WIDTH-1:0] mem_din;

  modport master (
    output mem_dout_addr,
    input  mem_dout,
    output mem_we,
    output mem_din_addr,
    output mem_din
  );

  modport slave (
    input  mem_dout_addr,
    output mem_dout,
    input  mem_we,
    input  mem_din_addr,
    input  mem_din
  );
endinterface

// File: rtl/dsram_dma.sv
// rtl/dsram_dma.sv - block copy / block fill engine sharing a distributed RAM with the CPU
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, mode           command strobe (taken only when idle), 0 = copy / 1 = fill
//   src, dst, len         source base, destination base, word count (0..2^WIDTH)
//   fill_value            word written in fill mode
//   abort                 terminate an active transfer
//   busy, done            transfer in progress, one-cycle completion pulse
//   cpu_re/cpu_raddr      CPU read request and address, cpu_rdata returned data
//   cpu_we/cpu_waddr/...  CPU write request, address and data
//   mem                   RAM port bundle (master side)
// The CPU always wins both RAM ports; the DMA moves one word in any cycle
// where the port(s) it needs are free.
module dsram_dma #(
  parameter int WIDTH      = 13,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      src,
  input  logic [WIDTH-1:0]      dst,
  input  logic [WIDTH:0]        len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  input  logic                  cpu_re,
  input  logic [WIDTH-1:0]      cpu_raddr,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  cpu_we,
  input  logic [WIDTH-1:0]      cpu_waddr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  dsram_dma_if.master           mem
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] PTR_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   REM_ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   REM_ZERO = '0;

  state_t                state, state_d;
  logic [WIDTH-1:0]      src_ptr, src_d;
  logic [WIDTH-1:0]      dst_ptr, dst_d;
  logic [WIDTH:0]        remaining, rem_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic                  done_q, done_d;
  logic                  step;
  logic                  copy_step;
  logic [DATA_WIDTH-1:0] dma_data;

  // Fill never reads the RAM, so only a copy yields to a CPU read.
  // Gating with rst_n keeps the reset cycle free of DMA writes.
  assign step = rst_n && (state == RUN) && !abort && !cpu_we && !(!mode_q && cpu_re);
  assign copy_step = step && !mode_q;
  assign dma_data  = mode_q ? fill_q : mem.mem_dout;

  assign mem.mem_dout_addr = copy_step ? src_ptr : cpu_raddr;
  assign mem.mem_we        = cpu_we | step;
  assign mem.mem_din_addr  = cpu_we ? cpu_waddr : dst_ptr;
  assign mem.mem_din       = cpu_we ? cpu_wdata : dma_data;
  assign cpu_rdata         = mem.mem_dout;

  assign busy = (state == RUN);
  assign done = done_q;

  always_comb begin
    state_d = state;
    src_d   = src_ptr;
    dst_d   = dst_ptr;
    rem_d   = remaining;
    mode_d  = mode_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          fill_d = fill_value;
          src_d  = src;
          dst_d  = dst;
          rem_d  = len;
          if (len == REM_ZERO) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (step) begin
          src_d = src_ptr + PTR_ONE;
          dst_d = dst_ptr + PTR_ONE;
          rem_d = remaining - REM_ONE;
          if (remaining == REM_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      mode_q    <= 1'b0;
      fill_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      src_ptr   <= src_d;
      dst_ptr   <= dst_d;
      remaining <= rem_d;
      mode_q    <= mode_d;
      fill_q    <= fill_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_dsram_dma.sv
// tb/tb_dsram_dma.sv - scoreboard testbench for dsram_dma
module tb_dsram_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [12:0] src;
  logic [12:0] dst;
  logic [13:0] len;
  logic [15:0] fill_value;
  logic        abort;
  logic        busy;
  logic        done;
  logic        cpu_re;
  logic [12:0] cpu_raddr;
  logic [15:0] cpu_rdata;
  logic        cpu_we;
  logic [12:0] cpu_waddr;
  logic [15:0] cpu_wdata;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic [15:0] ram [0:8191] = '{default: 16'h0000};

  always #5 clk = ~clk;

  dsram_dma_if #(.WIDTH(13), .DATA_WIDTH(16)) mem_bus ();

  dsram_dma #(.WIDTH(13), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_value(fill_value), .abort(abort), .busy(busy), .done(done),
    .cpu_re(cpu_re), .cpu_raddr(cpu_raddr), .cpu_rdata(cpu_rdata),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .mem(mem_bus)
  );

  assign mem_bus.mem_dout = ram[mem_bus.mem_dout_addr];
  always @(posedge clk) begin
    if (mem_bus.mem_we) ram[mem_bus.mem_din_addr] <= mem_bus.mem_din;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every DMA-owned write must match the next expected write.
  always @(negedge clk) begin : mon
    wr_t e;
    if (mem_bus.mem_we === 1'b1 && cpu_we === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr %h data %h expected none",
                 mem_bus.mem_din_addr, mem_bus.mem_din);
      end else begin
        e = exp_q.pop_front();
        chk("dma_addr", 32'(mem_bus.mem_din_addr), 32'(e.addr));
        chk("dma_data", 32'(mem_bus.mem_din), 32'(e.data));
      end
    end
  end

  task automatic push_fill(input logic [12:0] d, input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back({13'(d + 13'(i)), v});
  endtask

  task automatic start_cmd(input logic m, input logic [12:0] s, input logic [12:0] d,
                           input logic [13:0] l, input logic [15:0] f);
    @(posedge clk); #1;
    start = 1'b1; mode = m; src = s; dst = d; len = l; fill_value = f;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic cpu_write(input logic [12:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_waddr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_we = 1'b0;
  endtask

  // Counts busy cycles until the done pulse, then checks the pulse is one cycle wide.
  task automatic measure(input string name, output int busy_cyc);
    bit seen = 0;
    busy_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1;
        chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
        break;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    chk({name, "_done_width"}, 32'(done), 32'd0);
  endtask

  task automatic cpu_pulse(input int delay, input int n, input bit is_write);
    repeat (delay) @(posedge clk);
    #1;
    if (is_write) begin cpu_we = 1'b1; cpu_waddr = 13'h1000; cpu_wdata = 16'hBEEF; end
    else begin cpu_re = 1'b1; cpu_raddr = 13'h1000; end
    repeat (n) @(posedge clk);
    #1;
    cpu_we = 1'b0; cpu_re = 1'b0;
  endtask

  int bc;
  bit quiet;

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
    fill_value = '0; abort = 1'b0; cpu_re = 1'b0; cpu_raddr = '0;
    cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill 4 words at 0x0100
    push_fill(13'h0100, 4, 16'hA5A5);
    start_cmd(1'b1, 13'h0, 13'h0100, 14'd4, 16'hA5A5);
    measure("fill", bc);
    chk("fill_busy_cycles", 32'(bc), 32'd4);
    chk("fill_word3", 32'(ram[13'h0103]), 32'hA5A5);
    chk("fill_untouched", 32'(ram[13'h0104]), 32'h0);

    // Preload 1..8 and copy with two cycles of CPU write contention
    for (int i = 0; i < 8; i++) cpu_write(13'(i), 16'(i + 1));
    for (int i = 0; i < 8; i++) exp_q.push_back({13'(13'h0200 + 13'(i)), 16'(i + 1)});
    start_cmd(1'b0, 13'h0, 13'h0200, 14'd8, 16'h0);
    fork
      measure("copy_we", bc);
      cpu_pulse(3, 2, 1'b1);
    join
    chk("copy_we_busy_cycles", 32'(bc), 32'd10);
    chk("copy_we_cpu_word", 32'(ram[13'h1000]), 32'hBEEF);
    chk("copy_we_last", 32'(ram[13'h0207]), 32'd8);
    cpu_raddr = 13'h0203;
    @(negedge clk);
    chk("cpu_rdata", 32'(cpu_rdata), 32'd4);

    // Copy stalls on CPU reads, fill does not
    for (int i = 0; i < 4; i++) exp_q.push_back({13'(13'h0300 + 13'(i)), 16'(i + 1)});
    start_cmd(1'b0, 13'h0, 13'h0300, 14'd4, 16'h0);
    fork
      measure("copy_re", bc);
      cpu_pulse(1, 3, 1'b0);
    join
    chk("copy_re_busy_cycles", 32'(bc), 32'd7);
    push_fill(13'h0400, 4, 16'h3C3C);
    start_cmd(1'b1, 13'h0, 13'h0400, 14'd4, 16'h3C3C);
    fork
      measure("fill_re", bc);
      cpu_pulse(1, 3, 1'b0);
    join
    chk("fill_re_busy_cycles", 32'(bc), 32'd4);

    // Address wrap
    push_fill(13'h1FFE, 4, 16'h1234);
    start_cmd(1'b1, 13'h0, 13'h1FFE, 14'd4, 16'h1234);
    measure("wrap", bc);
    chk("wrap_low", 32'(ram[13'h0001]), 32'h1234);
    chk("wrap_high", 32'(ram[13'h1FFF]), 32'h1234);

    // Zero-length command
    start_cmd(1'b1, 13'h0, 13'h0600, 14'd0, 16'hFFFF);
    measure("len0", bc);
    chk("len0_busy_cycles", 32'(bc), 32'd0);

    // Abort after two words
    push_fill(13'h0500, 2, 16'h5555);
    start_cmd(1'b1, 13'h0, 13'h0500, 14'd6, 16'h5555);
    fork
      measure("abort", bc);
      begin
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
      end
    join
    chk("abort_busy_cycles", 32'(bc), 32'd3);
    chk("abort_word2", 32'(ram[13'h0502]), 32'h0);

    // Start while busy is ignored
    push_fill(13'h0600, 4, 16'h7777);
    start_cmd(1'b1, 13'h0, 13'h0600, 14'd4, 16'h7777);
    fork
      measure("ignored", bc);
      begin
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; src = 13'h0; dst = 13'h0700; len = 14'd2;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    chk("ignored_busy_cycles", 32'(bc), 32'd4);
    chk("ignored_dst", 32'(ram[13'h0700]), 32'h0);
    chk("ignored_fill", 32'(ram[13'h0603]), 32'h7777);

    // Reset mid-run
    push_fill(13'h0800, 2, 16'h9999);
    start_cmd(1'b1, 13'h0, 13'h0800, 14'd6, 16'h9999);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
    end
    chk("reset_mid_quiet", 32'(quiet), 32'd1);
    chk("reset_mid_word2", 32'(ram[13'h0802]), 32'h0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
